// File: rtl/sdma_arbiter.sv
// Round-robin arbiter sharing one fabric-to-SDMA channel among NUM_REQ clients.
// Optional SDMA_ARB_TIMEOUT_EN adds a request-to-done timeout with a sticky error flag.
module sdma_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned REQ_HOLD       = 3,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_W          = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_in,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] done_out,
    output logic               sdma_req,
    input  logic               sdma_active,
    input  logic               sdma_done,
    output logic               sdma_irq,
    output logic               busy,
    output logic               timeout_err
);

    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(REQ_HOLD - 1);
    // Counter never needs to count past the larger of the two terminal values.
    localparam logic [CNT_W-1:0] CntSat =
        (TIMEOUT_CYCLES > REQ_HOLD) ? CNT_W'(TIMEOUT_CYCLES - 1) : CNT_W'(REQ_HOLD - 1);
`ifdef SDMA_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {StIdle, StReq, StActive, StDone} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [PtrW-1:0]     ptr_q, ptr_d, sel_q, sel_d, pick;
    logic [PtrW:0]       sum;
    logic                found, xfer_end;
    logic [NUM_REQ-1:0]  grant_q, grant_d, done_q, done_d;
    logic                req_q, req_d, irq_q, irq_d, busy_q, busy_d;
`ifdef SDMA_ARB_TIMEOUT_EN
    logic                terr_q, terr_d;
`endif

    // First requesting client at or above the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr_q} + (PtrW+1)'(i);
            if (sum >= (PtrW+1)'(NUM_REQ)) sum = sum - (PtrW+1)'(NUM_REQ);
            if (!found && req_in[sum[PtrW-1:0]]) begin
                found = 1'b1;
                pick  = sum[PtrW-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        sel_d    = sel_q;
        grant_d  = grant_q;
        req_d    = req_q;
        done_d   = '0;
        irq_d    = 1'b0;
        busy_d   = busy_q;
        xfer_end = 1'b0;
        cnt_inc  = (cnt_q == CntSat) ? cnt_q : cnt_q + 1'b1;
`ifdef SDMA_ARB_TIMEOUT_EN
        terr_d   = terr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StReq;
                    sel_d   = pick;
                    grant_d = NUM_REQ'(1) << pick;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            StReq, StActive: begin
                cnt_d = cnt_inc;
                if (sdma_done) begin
                    xfer_end = 1'b1;
`ifdef SDMA_ARB_TIMEOUT_EN
                end else if (cnt_q == TimeoutLast) begin
                    xfer_end = 1'b1;
                    terr_d   = 1'b1;
`endif
                end else if (state_q == StReq && sdma_active && cnt_q >= HoldLast) begin
                    state_d = StActive;
                    req_d   = 1'b0;
                end
                if (xfer_end) begin
                    state_d = StDone;
                    req_d   = 1'b0;
                    grant_d = '0;
                    done_d  = NUM_REQ'(1) << sel_q;
                    irq_d   = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                ptr_d   = (sel_q == PtrW'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ptr_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            req_q   <= 1'b0;
            irq_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            req_q   <= req_d;
            irq_q   <= irq_d;
            busy_q  <= busy_d;
        end
    end

`ifdef SDMA_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) terr_q <= 1'b0;
        else     terr_q <= terr_d;
    end
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign grant    = grant_q;
    assign done_out = done_q;
    assign sdma_req = req_q;
    assign sdma_irq = irq_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_sdma_arbiter.sv
// Randomized bench for sdma_arbiter against a transaction-level reference model.
module tb_sdma_arbiter;

    localparam int NR   = 4;
    localparam int HOLD = 3;
    localparam int TMO  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req_in;
    logic [NR-1:0] grant, done_out;
    logic          sdma_req, sdma_active, sdma_done, sdma_irq, busy, timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    int ptr_m    = 0;
    bit terr_m   = 1'b0;

    sdma_arbiter #(
        .NUM_REQ(NR), .REQ_HOLD(HOLD), .TIMEOUT_CYCLES(TMO), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .grant(grant), .done_out(done_out),
        .sdma_req(sdma_req), .sdma_active(sdma_active), .sdma_done(sdma_done),
        .sdma_irq(sdma_irq), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NR-1:0] oh(input int i);
        logic [NR-1:0] one;
        one = 1;
        return one << i;
    endfunction

    function automatic int pick(input logic [NR-1:0] req, input int ptr);
        for (int i = 0; i < NR; i++)
            if (req[(ptr + i) % NR]) return (ptr + i) % NR;
        return -1;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, ".grant"}, 32'(grant), 0);
        check({tag, ".req"}, 32'(sdma_req), 0);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".done"}, 32'(done_out), 0);
        check({tag, ".irq"}, 32'(sdma_irq), 0);
        check({tag, ".terr"}, 32'(timeout_err), 32'(terr_m));
    endtask

    // a: first edge sampling sdma_active high; d: edge sampling sdma_done.
    // Called at a negedge with the DUT idle.
    task automatic run_txn(input logic [NR-1:0] req, input int a, input int d, input bit wiggle);
        int sel, fin, drop;
        bit tmo;
        sel = pick(req, ptr_m);
        fin = d;
        tmo = 1'b0;
`ifdef SDMA_ARB_TIMEOUT_EN
        if (d > TMO) begin
            fin = TMO;
            tmo = 1'b1;
        end
`endif
        drop = (a > HOLD) ? a : HOLD;
        if (drop > fin) drop = fin;
        req_in = req;
        sdma_active = 1'b0;
        sdma_done = 1'b0;
        for (int k = 1; k <= fin + 1; k++) begin
            @(negedge clk);
            if (k - 1 < fin) begin
                check("txn.grant", 32'(grant), 32'(oh(sel)));
                check("txn.req", 32'(sdma_req), 32'(k - 1 < drop));
                check("txn.busy", 32'(busy), 1);
                check("txn.done_early", 32'(done_out), 0);
                check("txn.irq_early", 32'(sdma_irq), 0);
            end else begin
                check("done.grant", 32'(grant), 0);
                check("done.req", 32'(sdma_req), 0);
                check("done.done_out", 32'(done_out), 32'(oh(sel)));
                check("done.irq", 32'(sdma_irq), 1);
                check("done.busy", 32'(busy), 1);
                check("done.terr", 32'(timeout_err), 32'(terr_m | tmo));
            end
            sdma_active = (k >= a) && (k <= fin);
            sdma_done   = (k == d);
            if (wiggle) req_in = NR'($urandom);
        end
        @(negedge clk);
        terr_m = terr_m | tmo;
        ptr_m  = (sel + 1) % NR;
        check_idle("gap");
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req_in = '0;
        sdma_active = 1'b0;
        sdma_done = 1'b0;
        #1;
        ptr_m = 0;
        terr_m = 1'b0;
        check_idle("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        req_in = '0;
        sdma_active = 1'b0;
        sdma_done = 1'b0;
        #2;
        apply_reset();

        // Single client, long transfer.
        run_txn(4'b0001, 1, 11, 1'b0);

        // Round robin from a fresh pointer.
        apply_reset();
        for (int i = 0; i < 5; i++) run_txn(4'b1111, 1, 5, 1'b0);

        // Pointer wrap.
        run_txn(4'b1000, 2, 6, 1'b0);
        run_txn(4'b1001, 1, 4, 1'b0);
        run_txn(4'b1001, 1, 4, 1'b0);

        // Early done with sdma_active never high.
        run_txn(4'b0010, 1000, 2, 1'b0);

        // Reset mid-ACTIVE with client 2 owning the channel.
        apply_reset();
        req_in = 4'b0100;
        @(negedge clk);
        check("rst.grant_before", 32'(grant), 32'b0100);
        sdma_active = 1'b1;
        repeat (5) @(negedge clk);
        check("rst.active_grant", 32'(grant), 32'b0100);
        check("rst.active_req", 32'(sdma_req), 0);
        #2;
        rst = 1'b1;
        #1;
        ptr_m = 0;
        terr_m = 1'b0;
        check_idle("rst.async");
        sdma_active = 1'b0;
        req_in = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_idle("rst.after");
        end
        run_txn(4'b1111, 1, 4, 1'b0);

        // Randomized transactions, including dropped/changed req_in mid-transfer.
        for (int n = 0; n < 60; n++) begin
            logic [NR-1:0] r;
            int a, d;
            r = NR'($urandom_range(1, 15));
            a = ($urandom_range(0, 4) == 0) ? 1000 : int'($urandom_range(1, 6));
            d = int'($urandom_range(1, 22));
            run_txn(r, a, d, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
